dtc_tx_framer: RTL
==================

# dtc_tx_framer

Transmit-side word framer for the DTC link: each bitclkdiv cycle it produces the 16-bit parallel word fed to the DTC output serializer. It keeps the line filled with the 16'hBC50 idle/comma word that the far-end deserializer uses for bitslip word alignment and bit-error counting. On request it emits a guaranteed training burst of that word. It wraps upstream payload words into frames (SOF, payload, checksum, EOF).

## Interface
Parameters:
- IDLE_WORD, 16'hBC50, idle/alignment word; matches the receiver's alignment pattern.
- SOF_WORD, 16'h5CFB, start-of-frame marker.
- EOF_WORD, 16'hFD5C, end-of-frame marker.
- TRAIN_LEN, 16'd4096, number of IDLE_WORD cycles in a training burst (≥ 3000; covers 250 slips × ~11 cycles at the receiver).
- MAX_LEN, 10'd512, maximum payload words per frame (≥ 2).

Ports:
- bitclkdiv  in  1  word clock, the serializer CLKDIV domain; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- train_start  in  1  one-cycle request for a training burst.
- errinj  in  1  one-cycle request to corrupt one idle word.
- tx_data  in  16  payload word.
- tx_valid  in  1  tx_data valid.
- tx_last  in  1  tx_data is the final payload word of the frame.
- tx_ready  out  1  payload word accepted on this edge if tx_valid; equals (state == DATA).
- dtc_ser_din  out  16  registered word to serializer.
- busy  out  1  state ≠ IDLE.
- training  out  1  state == TRAIN.
- frame_cnt  out  16  frames completed, wraps 16'hFFFF→0.
- len_err  out  1  sticky: a frame was truncated at MAX_LEN.

## Operation
- States: IDLE, TRAIN, SOF, DATA, CSUM, EOF. One-hot; an illegal encoding recovers to IDLE.
- IDLE: emit IDLE_WORD, or ~IDLE_WORD if errinj_pend is set (errinj_pend then clears). Priority: train_pend → TRAIN (train_pend clears, train counter clears); else tx_valid → SOF; else stay.
- TRAIN: emit IDLE_WORD; errinj_pend is held, not consumed. Counter increments each cycle; when count == TRAIN_LEN-1 → IDLE. Exactly TRAIN_LEN TRAIN cycles.
- SOF: emit SOF_WORD; csum ← 0, wcnt ← 0; → DATA.
- DATA: on tx_valid: emit tx_data, csum ← csum + tx_data (mod 2^16), wcnt ← wcnt+1. If tx_last, or wcnt == MAX_LEN-1: → CSUM. In the truncation case without tx_last, set len_err. With !tx_valid: emit IDLE_WORD as fill and stay.
- CSUM: emit csum (sum of all payload words, including the last); → EOF.
- EOF: emit EOF_WORD; frame_cnt ← frame_cnt+1; → IDLE.
- train_start and errinj are latched into train_pend/errinj_pend in any state. A repeat request while pending is absorbed (no queueing).
- train_start mid-frame never aborts the frame; the burst begins after EOF.
- len_err clears only on reset. After truncation, remaining upstream words form a new frame.

## Timing
- All outputs registered except tx_ready (decoded from the state register).
- Reset (async assert, synchronous release): dtc_ser_din = IDLE_WORD, state IDLE, tx_ready 0, busy 0, training 0, frame_cnt 0, len_err 0, pendings 0, csum/wcnt/counter 0.
- Output timing: the word selected during a cycle appears on dtc_ser_din after the next edge.
- tx_valid high in IDLE at edge k: SOF_WORD is out after k+1, and the earliest payload word is out after k+2.
- Last word accepted at edge m: csum is out after m+1, EOF_WORD after m+2, IDLE_WORD after m+3.
- Back-to-back frames: minimum 1 IDLE_WORD between EOF_WORD and the next SOF_WORD.
- train_start at edge k in IDLE (nothing pending): first TRAIN word after k+2, last after k+1+TRAIN_LEN.
- Reset mid-frame: frame abandoned, output IDLE_WORD immediately; frame_cnt is not incremented.

## Test plan
- Reset, then 20 idle cycles → dtc_ser_din = 16'hBC50 every cycle; busy 0, tx_ready 0.
- Frame 16'h0001, 16'h0002, 16'h8000 (last), tx_valid continuous → sequence 5CFB, 0001, 0002, 8000, 8003, FD5C, BC50; frame_cnt = 1.
- Same frame with tx_valid low for 2 cycles after word 1 → two BC50 fills between 0001 and 0002; checksum still 8003.
- train_start with TRAIN_LEN = 16 → exactly 16 BC50 cycles with training = 1. The checksum of an 8-bit deserializer-side check shows 0 errors.
- train_start and errinj asserted mid-frame → frame completes intact, then 16 TRAIN cycles, then one 16'h43AF word, then BC50.
- MAX_LEN = 4, 6 words with tx_last on the 6th → first frame carries 4 words then csum/EOF, len_err = 1; second frame carries 2 words.
- reset_n pulsed low mid-DATA → output BC50 immediately, frame_cnt unchanged, tx_ready 0.

Source files
------------

// File: rtl/dtc_tx_framer_if.sv
// dtc_tx_framer_if: payload handshake between an upstream word source and the DTC transmit framer
//   tx_data  : payload word
//   tx_valid : tx_data valid
//   tx_last  : tx_data is the final payload word of the frame
//   tx_ready : framer accepts the word on this edge if tx_valid
interface dtc_tx_framer_if;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    modport master (output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/dtc_tx_framer.sv
// dtc_tx_framer: DTC link word framer -- idle/comma fill, training bursts, SOF/payload/checksum/EOF frames
//   bitclkdiv   : word clock (serializer CLKDIV domain)
//   reset_n     : asynchronous active-low reset
//   train_start : one-cycle training burst request
//   errinj      : one-cycle request to corrupt one idle word
//   tx          : payload handshake (slave side)
//   dtc_ser_din : registered 16-bit word to the serializer
//   busy        : framer not idle
//   training    : training burst in progress
//   frame_cnt   : completed frames, wrapping
//   len_err     : sticky, a frame was truncated at MAX_LEN
module dtc_tx_framer #(
    parameter logic [15:0] IDLE_WORD = 16'hBC50,
    parameter logic [15:0] SOF_WORD  = 16'h5CFB,
    parameter logic [15:0] EOF_WORD  = 16'hFD5C,
    parameter logic [15:0] TRAIN_LEN = 16'd4096,
    parameter logic [9:0]  MAX_LEN   = 10'd512
) (
    input  logic           bitclkdiv,
    input  logic           reset_n,
    input  logic           train_start,
    input  logic           errinj,
    dtc_tx_framer_if.slave tx,
    output logic [15:0]    dtc_ser_din,
    output logic           busy,
    output logic           training,
    output logic [15:0]    frame_cnt,
    output logic           len_err
);
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        TRAIN = 6'b000010,
        SOF   = 6'b000100,
        DATA  = 6'b001000,
        CSUM  = 6'b010000,
        EOF   = 6'b100000
    } state_t;
    state_t      state, state_nx;
    logic [15:0] csum, csum_nx, train_cnt, train_cnt_nx, word_nx;
    logic [9:0]  wcnt, wcnt_nx;
    logic        train_pend, errinj_pend, train_take, errinj_take, len_set, frame_done;
    assign tx.tx_ready = (state == DATA);
    always_comb begin
        state_nx     = IDLE;
        word_nx      = IDLE_WORD;
        csum_nx      = csum;
        wcnt_nx      = wcnt;
        train_cnt_nx = train_cnt;
        train_take   = 1'b0;
        errinj_take  = 1'b0;
        len_set      = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                // a pending burst goes first; a pending error injection waits so it lands after the burst
                if (train_pend) begin
                    state_nx     = TRAIN;
                    train_take   = 1'b1;
                    train_cnt_nx = '0;
                end else begin
                    errinj_take = errinj_pend;
                    word_nx     = errinj_pend ? ~IDLE_WORD : IDLE_WORD;
                    state_nx    = tx.tx_valid ? SOF : IDLE;
                end
            end
            TRAIN: begin
                train_cnt_nx = train_cnt + 16'd1;
                state_nx     = (train_cnt == TRAIN_LEN - 16'd1) ? IDLE : TRAIN;
            end
            SOF: begin
                word_nx  = SOF_WORD;
                csum_nx  = '0;
                wcnt_nx  = '0;
                state_nx = DATA;
            end
            DATA: begin
                state_nx = DATA;
                if (tx.tx_valid) begin
                    word_nx  = tx.tx_data;
                    csum_nx  = csum + tx.tx_data;
                    wcnt_nx  = wcnt + 10'd1;
                    state_nx = (tx.tx_last || wcnt == MAX_LEN - 10'd1) ? CSUM : DATA;
                    len_set  = !tx.tx_last && wcnt == MAX_LEN - 10'd1;
                end
            end
            CSUM: begin
                word_nx  = csum;
                state_nx = EOF;
            end
            EOF: begin
                word_nx    = EOF_WORD;
                frame_done = 1'b1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge bitclkdiv or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dtc_ser_din <= IDLE_WORD;
            busy        <= 1'b0;
            training    <= 1'b0;
            frame_cnt   <= '0;
            len_err     <= 1'b0;
            train_pend  <= 1'b0;
            errinj_pend <= 1'b0;
            csum        <= '0;
            wcnt        <= '0;
            train_cnt   <= '0;
        end else begin
            state       <= state_nx;
            dtc_ser_din <= word_nx;
            busy        <= state_nx != IDLE;
            training    <= state_nx == TRAIN;
            frame_cnt   <= frame_cnt + {15'd0, frame_done};
            len_err     <= len_err | len_set;
            // a request arriving while one is pending (including the consuming edge) is absorbed
            train_pend  <= train_take ? 1'b0 : (train_pend | train_start);
            errinj_pend <= errinj_take ? 1'b0 : (errinj_pend | errinj);
            csum        <= csum_nx;
            wcnt        <= wcnt_nx;
            train_cnt   <= train_cnt_nx;
        end
    end
endmodule
